// File: rtl/gates_pkg.sv
// gates_pkg: shared types for the gates_pipe bitwise logic unit.
//   OP_W       - opcode width in bits
//   gates_op_e - the eight two-operand bitwise functions
package gates_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_ORN  = 3'd7
  } gates_op_e;

endpackage

// File: rtl/gates_op_core.sv
// gates_op_core: purely combinational bitwise function unit.
// Ports:
//   op - function select (gates_op_e)
//   a  - operand A, WIDTH bits
//   b  - operand B, WIDTH bits
//   y  - result, WIDTH bits
module gates_op_core
  import gates_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  gates_op_e        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gates_pipe.sv
// gates_pipe: two-stage valid/ready pipelined bitwise logic unit.
// Optional feature macro: GATES_FLAGS_EN (adds registered result flags).
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - upstream offers op/a/b
//   in_ready  - transaction accepted this cycle when in_valid is high
//   op        - function select
//   a, b      - WIDTH-bit operands
//   out_valid - result y available
//   out_ready - downstream accepts y
//   y         - WIDTH-bit result
//   flag_zero - (GATES_FLAGS_EN) y == 0
//   flag_ones - (GATES_FLAGS_EN) y == all ones
//   flag_par  - (GATES_FLAGS_EN) XOR reduction of y
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload until the transfer;
// this block holds out_valid and y (and flags) stable until out_ready.
module gates_pipe
  import gates_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GATES_FLAGS_EN
  ,output logic            flag_zero
  ,output logic            flag_ones
  ,output logic            flag_par
`endif
);

  // Stage 1 holding registers.
  logic             s1_v;
  gates_op_e        s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_adv;
  logic             accept;
  logic [WIDTH-1:0] core_y;

  // S1 moves into S2 whenever S2 is empty or being drained this cycle;
  // in_ready therefore depends combinationally on out_ready only.
  assign s2_adv   = s1_v & (~out_valid | out_ready);
  assign in_ready = ~s1_v | s2_adv;
  assign accept   = in_valid & in_ready;

  gates_op_core #(.WIDTH(WIDTH)) u_core (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (core_y)
  );

  // Stage 1: load on acceptance, empty when it advances without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= OP_AND;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (accept) begin
      s1_v  <= 1'b1;
      s1_op <= gates_op_e'(op);
      s1_a  <= a;
      s1_b  <= b;
    end else if (s2_adv) begin
      s1_v  <= 1'b0;
    end
  end

  // Stage 2: y only changes when a new result arrives, so it is held
  // through any stall and after the last result drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      y         <= core_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GATES_FLAGS_EN
  // Flags track y exactly, so their reset values describe y == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_zero <= 1'b1;
      flag_ones <= 1'b0;
      flag_par  <= 1'b0;
    end else if (s2_adv) begin
      flag_zero <= (core_y == '0);
      flag_ones <= (core_y == '1);
      flag_par  <= ^core_y;
    end
  end
`endif

endmodule

// File: tb/tb_gates_pipe.sv
// tb_gates_pipe: self-checking bench for gates_pipe (WIDTH = 8).
module tb_gates_pipe;

  localparam int WIDTH = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       op        = '0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] y;
`ifdef GATES_FLAGS_EN
  logic             flag_zero;
  logic             flag_ones;
  logic             flag_par;
`endif

  gates_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef GATES_FLAGS_EN
    ,.flag_zero (flag_zero)
    ,.flag_ones (flag_ones)
    ,.flag_par  (flag_par)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each opcode is a 2-input truth table indexed {a_bit,b_bit}.
  localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                    4'b0001, 4'b1001, 4'b0100, 4'b1101};

  function automatic logic [WIDTH-1:0] ref_fn(input int o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [3:0]       t;
    logic [WIDTH-1:0] r;
    logic [1:0]       idx;
    t = TT[o];
    for (int i = 0; i < WIDTH; i++) begin
      idx  = {x[i], z[i]};
      r[i] = t[idx];
    end
    return r;
  endfunction

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int c = 0;
    for (int i = 0; i < WIDTH; i++) c += int'(v[i]);
    return c;
  endfunction

  // Scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               out_cyc[$];
  int               acc_cyc[$];
  bit               mon_en     = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_y     = '0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_y", 32'(y), 32'(prev_y));
      end
      if (out_valid && out_ready) begin
        chk("out_expected_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk("out_y", 32'(y), 32'(e));
`ifdef GATES_FLAGS_EN
          chk("out_flag_zero", 32'(flag_zero), 32'(popcount(e) == 0));
          chk("out_flag_ones", 32'(flag_ones), 32'(popcount(e) == WIDTH));
          chk("out_flag_par", 32'(flag_par), 32'(popcount(e) % 2));
`endif
        end
        out_log.push_back(y);
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fn(int'(op), a, b));
        acc_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1 after acceptance.
  task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] z, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = z;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        chk("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      n++;
      if (n > 200) begin
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

`ifdef GATES_FLAGS_EN
  task automatic wait_out();
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 20) begin
        chk("wait_out_timeout", 32'(out_valid), 32'd1);
        break;
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] SWEEP [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF,
                                       8'h03, 8'h33, 8'hC0, 8'hF3};

  initial begin
    int         w;
    bit         acc;
    logic [7:0] sv;

    // Reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef GATES_FLAGS_EN
    chk("rst_flag_zero", 32'(flag_zero), 32'd1);
    chk("rst_flag_ones", 32'(flag_ones), 32'd0);
    chk("rst_flag_par", 32'(flag_par), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Opcode sweep
    out_ready = 1'b1;
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      send(3'(k), 8'hF0, 8'h3C, w);
      chk("sweep_no_wait", 32'(w), 32'd0);
    end
    drain();
    chk("sweep_count", 32'(out_log.size()), 32'd8);
    if (out_log.size() == 8) begin
      chk("sweep_latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd2);
      for (int k = 0; k < 8; k++) begin
        sv = SWEEP[k];
        chk($sformatf("sweep_y_op%0d", k), 32'(out_log[k]), 32'(sv));
        chk($sformatf("sweep_cycle_op%0d", k), 32'(out_cyc[k] - out_cyc[0]), 32'(k));
      end
    end

    // Backpressure: capacity of two, third waits
    out_ready = 1'b0;
    clear_logs();
    send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), w);
    chk("bp_first_wait", 32'(w), 32'd0);
    send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), w);
    chk("bp_second_wait", 32'(w), 32'd0);
    in_valid = 1'b1;
    op = 3'($urandom_range(0, 7));
    a  = 8'($urandom);
    b  = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(out_log.size()), 32'd3);

    // Full throughput
    clear_logs();
    for (int k = 0; k < 16; k++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), w);
      chk("tput_no_wait", 32'(w), 32'd0);
    end
    drain();
    chk("tput_count", 32'(out_log.size()), 32'd16);
    if (out_cyc.size() == 16)
      chk("tput_back_to_back", 32'(out_cyc[15] - out_cyc[0]), 32'd15);

    // Random stall
    clear_logs();
    acc = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_no_loss", 32'(out_log.size()), 32'(acc_cyc.size()));

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(3'd2, 8'hA5, 8'h0F, w);
    send(3'd1, 8'h11, 8'h22, w);
    chk("mid_full_out_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("mid_in_ready_after", 32'(in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

`ifdef GATES_FLAGS_EN
    // Flags
    send(3'd2, 8'hFF, 8'hFF, w);
    wait_out();
    chk("flag_xor_zero", 32'(flag_zero), 32'd1);
    chk("flag_xor_par", 32'(flag_par), 32'd0);
    @(posedge clk); #1;
    send(3'd0, 8'hFF, 8'hFF, w);
    wait_out();
    chk("flag_and_ones", 32'(flag_ones), 32'd1);
    @(posedge clk); #1;
    send(3'd1, 8'h01, 8'h00, w);
    wait_out();
    chk("flag_or_par", 32'(flag_par), 32'd1);
    @(posedge clk); #1;
    drain();
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gates_pipe.md
# gates_pipe

Parametrised, pipelined bitwise logic unit. It is the successor to the fixed single-bit gate set. Each accepted transaction applies one of eight two-operand bitwise functions, selected by opcode, to two WIDTH-bit operands, and returns the WIDTH-bit result through a two-stage valid/ready pipeline with full backpressure. It sits between any operand producer and result consumer that use valid/ready streaming.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1)

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst, input, 1, reset, asynchronous, active-high
- in_valid, input, 1, upstream offers a transaction
- in_ready, output, 1, block accepts a transaction this cycle
- op, input, 3, function select, sampled with in_valid & in_ready
- a, input, WIDTH, operand A
- b, input, WIDTH, operand B
- out_valid, output, 1, result available
- out_ready, input, 1, downstream accepts the result
- y, output, WIDTH, result
- flag_zero, output, 1, only with GATES_FLAGS_EN: y == 0
- flag_ones, output, 1, only with GATES_FLAGS_EN: y == all ones
- flag_par, output, 1, only with GATES_FLAGS_EN: XOR reduction of y

## Operation
- Opcodes:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 XOR: a^b
  - 3 NAND: ~(a&b)
  - 4 NOR: ~(a|b)
  - 5 XNOR: ~(a^b)
  - 6 ANDN: a&~b
  - 7 ORN: a|~b
- All eight opcodes are legal. There is no error path.
- Stage 1 (S1) registers op, a and b and sets s1_v. Stage 2 (S2) registers the computed result and sets out_valid.
- Advance rules:
  - s2_adv = s1_v & (~out_valid | out_ready)
  - in_ready = ~s1_v | s2_adv
- Acceptance: the input is accepted iff in_valid & in_ready. S1 loads on acceptance and clears when it advances with no new acceptance.
- Output hold: S2 holds y stable while out_valid & ~out_ready.
- Ordering: results leave strictly in acceptance order. There is no drop and no duplication.
- Simultaneous events: with out_valid & out_ready & s1_v & in_valid, all stages shift in the same cycle. Throughput is 1 per cycle.
- Reset values: out_valid=0, y=0, s1_v=0. With GATES_FLAGS_EN, flags are computed from y=0, so flag_zero=1, flag_ones=0 and flag_par=0.
- Reset mid-operation: any in-flight transactions are discarded. in_ready=1 from the first cycle after rst deasserts.

## Timing
- Latency: an input accepted on edge N gives out_valid=1 with the result after edge N+1, when the pipeline is not stalled.
- in_ready is combinational from out_ready. There is no combinational path from in_valid, a or b to any output.
- Capacity: two transactions. With out_ready held at 0, exactly two are accepted before in_ready drops.
- Flags, when enabled, are registered alongside y in S2 and change on the same edge as y.

## Configuration
- Macro: GATES_FLAGS_EN.
- Defined: the flag_zero, flag_ones and flag_par ports exist and are registered in S2.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package gates_pkg:
  - 3-bit opcode enum gates_op_e: OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_ORN
  - OP_W = 3
- Sub-module gates_op_core: purely combinational, parametrised by WIDTH, maps (op, a, b) to the result. It is instantiated once between S1 and S2.
- Pipeline control and registers live in gates_pipe.

## Test plan
All scenarios use WIDTH=8.
- Opcode sweep: a=F0, b=3C, out_ready=1, op=0..7 on consecutive cycles -> y=30,FC,CC,CF,03,33,C0,F3 on consecutive cycles, the first 2 cycles after the first acceptance.
- Backpressure: out_ready=0, in_valid=1 with three transactions -> first two accepted, in_ready=0 on the third. Raising out_ready -> all three emerge in order, y held stable while stalled.
- Full throughput: 16 back-to-back random transactions, out_ready=1 -> in_ready stays 1, one result per cycle, all match the reference model.
- Random stall: random in_valid and out_ready for 1000 cycles -> scoreboard reports no loss, no duplicates, in order, and y stable whenever out_valid & ~out_ready.
- Reset mid-stream: assert rst with both stages full -> out_valid=0 and y=00 immediately. After release, in_ready=1 and no stale result appears.
- Flags (GATES_FLAGS_EN): a=FF, b=FF, op=XOR -> flag_zero=1, flag_par=0. Then op=AND -> flag_ones=1. Then a=01, b=00, op=OR -> flag_par=1.
